// File: rtl/sng_pkg.sv
// Shared defaults and types for the stop-and-go keystream word packer.
package sng_pkg;

   localparam int SNG_WORD_W     = 32;
   localparam int SNG_FIFO_DEPTH = 4;
   localparam int SNG_RUN_LIMIT  = 34;

   typedef logic [SNG_WORD_W-1:0] sng_word_t;

   function automatic bit sng_is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/sng_sync_fifo.sv
// Synchronous word FIFO with registered level; a push into a full FIFO
// succeeds only when a pop happens on the same edge.
module sng_sync_fifo
   import sng_pkg::*;
#(
   parameter int W     = SNG_WORD_W,
   parameter int DEPTH = SNG_FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);

   if (!sng_is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("sng_sync_fifo: DEPTH must be a power of two >= 2");
   end

   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]        wr_q, wr_d, rd_q, rd_d;
   logic [LVL_W-1:0]        level_q, level_d;
   logic                    do_push_s, do_pop_s;

   assign full  = (level_q == LVL_W'(DEPTH));
   assign empty = (level_q == LVL_W'(0));
   assign level = level_q;
   // Slots are zeroed on reset/flush so the head reads 0 until the first push.
   assign rdata = mem_q[rd_q];

   always_comb begin
      mem_d     = mem_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      level_d   = level_q;
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
      if (flush) begin
         mem_d   = '0;
         wr_d    = '0;
         rd_d    = '0;
         level_d = '0;
      end else begin
         if (do_push_s) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + PTR_W'(1);
         end else begin
            wr_d = wr_q;
         end
         if (do_pop_s) begin
            rd_d = rd_q + PTR_W'(1);
         end else begin
            rd_d = rd_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/sng_word_packer.sv
// Packs the 1-bit keystream MSB-first into words and buffers them in a FIFO.
// Define SNG_HEALTH_EN to build the run-length health monitor.
module sng_word_packer
   import sng_pkg::*;
#(
   parameter int WORD_W     = SNG_WORD_W,
   parameter int FIFO_DEPTH = SNG_FIFO_DEPTH,
   parameter int RUN_LIMIT  = SNG_RUN_LIMIT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            bit_in,
   input  logic                            bit_en,
   input  logic                            flush,
   output logic [WORD_W-1:0]               out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
   output logic                            overflow,
   output logic                            health_fail
);

   localparam int BCNT_W = $clog2(WORD_W);

   if (WORD_W < 2) begin : g_bad_word_w
      $error("sng_word_packer: WORD_W must be >= 2");
   end
   if (RUN_LIMIT < 2) begin : g_bad_run_limit
      $error("sng_word_packer: RUN_LIMIT must be >= 2");
   end

   logic [WORD_W-2:0] shreg_q, shreg_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic              overflow_q, overflow_d;
   logic [WORD_W-1:0] word_s;
   logic              push_s, pop_s, full_s, empty_s;

   always_comb begin
      shreg_d    = shreg_q;
      bcnt_d     = bcnt_q;
      word_s     = {shreg_q, bit_in};
      push_s     = bit_en && !flush && (bcnt_q == BCNT_W'(WORD_W - 1));
      pop_s      = !empty_s && out_ready && !flush;
      // A completed word is lost only when the FIFO is full and nothing leaves.
      overflow_d = overflow_q | (push_s & full_s & ~pop_s);
      if (flush) begin
         shreg_d = '0;
         bcnt_d  = '0;
      end else if (bit_en) begin
         shreg_d = word_s[WORD_W-2:0];
         if (push_s) begin
            bcnt_d = '0;
         end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
         end
      end else begin
         shreg_d = shreg_q;
         bcnt_d  = bcnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg_q    <= '0;
         bcnt_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         shreg_q    <= shreg_d;
         bcnt_q     <= bcnt_d;
         overflow_q <= overflow_d;
      end
   end

   sng_sync_fifo #(
      .W     (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (word_s),
      .rdata (out_data),
      .level (level),
      .full  (full_s),
      .empty (empty_s)
   );

   assign out_valid = !empty_s;
   assign overflow  = overflow_q;

`ifdef SNG_HEALTH_EN
   localparam int RUN_W = $clog2(RUN_LIMIT + 1);

   logic [RUN_W-1:0] run_q, run_d;
   logic             last_bit_q, last_bit_d;
   logic             health_q, health_d;

   // run==0 marks "no bit seen since reset/flush", so the next bit starts a run.
   always_comb begin
      run_d      = run_q;
      last_bit_d = last_bit_q;
      health_d   = health_q;
      if (flush) begin
         run_d      = '0;
         last_bit_d = 1'b0;
      end else if (bit_en) begin
         last_bit_d = bit_in;
         if (run_q == RUN_W'(0) || bit_in != last_bit_q) begin
            run_d = RUN_W'(1);
         end else if (run_q != RUN_W'(RUN_LIMIT)) begin
            run_d = run_q + RUN_W'(1);
         end else begin
            run_d = run_q;
         end
         if (run_d == RUN_W'(RUN_LIMIT)) begin
            health_d = 1'b1;
         end else begin
            health_d = health_q;
         end
      end else begin
         run_d = run_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         run_q      <= '0;
         last_bit_q <= 1'b0;
         health_q   <= 1'b0;
      end else begin
         run_q      <= run_d;
         last_bit_q <= last_bit_d;
         health_q   <= health_d;
      end
   end

   assign health_fail = health_q;
`else
   assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_sng_word_packer.sv
// Directed self-checking bench for sng_word_packer (WORD_W=8, FIFO_DEPTH=2).
module tb_sng_word_packer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_en = 1'b0;
   logic       flush = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic [1:0] level;
   logic       overflow;
   logic       health_fail;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sng_word_packer #(
      .WORD_W     (8),
      .FIFO_DEPTH (2),
      .RUN_LIMIT  (34)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bit_in      (bit_in),
      .bit_en      (bit_en),
      .flush       (flush),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .level       (level),
      .overflow    (overflow),
      .health_fail (health_fail)
   );

   task automatic drive(input logic b, input logic en);
      bit_in = b;
      bit_en = en;
      @(posedge clk);
      #1;
      bit_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      flush = 1'b0;
      bit_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      out_ready = 1'b0;
      do_reset();
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL reset_health: got %b want 0", health_fail); end
   endtask

   task automatic test_basic_pack();
      logic [7:0] pat;
      logic       early;
      pat = 8'hB2;
      early = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(pat[7-i], 1'b1);
         if (i < 7 && out_valid) early = 1'b1;
      end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL basic_early: got valid before 8th bit"); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      checks++; if (out_data !== 8'hB2) begin errors++; $display("FAIL basic_data: got %h want b2", out_data); end
      drive(1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b want 0", out_valid); end
   endtask

   task automatic test_stall();
      logic [7:0] pat;
      logic       early;
      pat = 8'hB2;
      early = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(pat[7-i], 1'b1);
         if (out_valid) early = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0);
         if (out_valid) early = 1'b1;
      end
      for (int i = 4; i < 8; i++) begin
         drive(pat[7-i], 1'b1);
         if (i < 7 && out_valid) early = 1'b1;
      end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL stall_early: got valid during stall"); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hB2) begin errors++; $display("FAIL stall_word: got v=%b d=%h want v=1 d=b2", out_valid, out_data); end
      drive(1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_one_cycle: got %b want 0", out_valid); end
   endtask

   task automatic test_overflow();
      logic [23:0] bits;
      bits = 24'h3CC35A;
      out_ready = 1'b0;
      for (int i = 0; i < 24; i++) begin
         drive(bits[23-i], 1'b1);
         if (i == 15) begin
            checks++; if (level !== 2'd2 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full: got lvl=%0d ovf=%b want lvl=2 ovf=0", level, overflow); end
         end
      end
      checks++; if (level !== 2'd2) begin errors++; $display("FAIL ovf_level: got %0d want 2", level); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL ovf_head: got %h want 3c", out_data); end
      out_ready = 1'b1;
      drive(1'b0, 1'b0);
      checks++; if (out_data !== 8'hC3 || level !== 2'd1) begin errors++; $display("FAIL ovf_drain1: got d=%h lvl=%0d want d=c3 lvl=1", out_data, level); end
      drive(1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL ovf_drain2: got v=%b lvl=%0d want v=0 lvl=0", out_valid, level); end
   endtask

   task automatic test_flush();
      logic [7:0] pat;
      logic [7:0] pat2;
      pat = 8'hA5;
      pat2 = 8'h69;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
      flush = 1'b1;
      drive(1'b1, 1'b1);
      flush = 1'b0;
      checks++; if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL flush_clear: got lvl=%0d v=%b d=%h want 0 0 00", level, out_valid, out_data); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_keeps_ovf: got %b want 1", overflow); end
      for (int i = 0; i < 8; i++) drive(pat[7-i], 1'b1);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL flush_word: got v=%b d=%h want v=1 d=a5", out_valid, out_data); end
      drive(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
      do_reset();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_clears_ovf: got %b want 0", overflow); end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) drive(pat2[7-i], 1'b1);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h69) begin errors++; $display("FAIL rst_midword: got v=%b d=%h want v=1 d=69", out_valid, out_data); end
      drive(1'b0, 1'b0);
   endtask

   task automatic test_full_push_pop();
      logic [23:0] bits;
      bits = 24'h112233;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 23; i++) drive(bits[23-i], 1'b1);
      checks++; if (level !== 2'd2) begin errors++; $display("FAIL fpp_prefill: got %0d want 2", level); end
      out_ready = 1'b1;
      drive(bits[0], 1'b1);
      checks++; if (level !== 2'd2 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_level: got lvl=%0d ovf=%b want lvl=2 ovf=0", level, overflow); end
      checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL fpp_head: got %h want 22", out_data); end
      drive(1'b0, 1'b0);
      checks++; if (out_data !== 8'h33 || level !== 2'd1) begin errors++; $display("FAIL fpp_third: got d=%h lvl=%0d want d=33 lvl=1", out_data, level); end
      drive(1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_health();
      do_reset();
      out_ready = 1'b1;
`ifdef SNG_HEALTH_EN
      for (int i = 0; i < 33; i++) drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL health_33: got %b want 0", health_fail); end
      for (int i = 0; i < 34; i++) begin
         drive(1'b1, 1'b1);
         if (i == 5) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hBF) begin errors++; $display("FAIL health_pack: got v=%b d=%h want v=1 d=bf", out_valid, out_data); end
         end
         if (i == 32) begin
            checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL health_early: got %b want 0", health_fail); end
         end
      end
      checks++; if (health_fail !== 1'b1) begin errors++; $display("FAIL health_34: got %b want 1", health_fail); end
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hF0 || health_fail !== 1'b1) begin errors++; $display("FAIL health_after: got v=%b d=%h h=%b want v=1 d=f0 h=1", out_valid, out_data, health_fail); end
`else
      for (int i = 0; i < 40; i++) drive(1'b1, 1'b1);
      checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL health_off: got %b want 0", health_fail); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin errors++; $display("FAIL health_off_pack: got v=%b d=%h want v=1 d=ff", out_valid, out_data); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic_pack();
      test_stall();
      test_overflow();
      test_flush();
      test_full_push_pop();
      test_health();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sng_word_packer.md
# sng_word_packer

Downstream consumer of the alternating stop-and-go keystream generator. Takes the generator's 1-bit keystream output, assembles it MSB-first into WORD_W-bit words, and buffers completed words in a small synchronous FIFO behind a valid/ready output. An optional run-length health monitor flags a stuck or degenerate keystream. Sits between the PRSG and any word-oriented consumer, such as a cipher XOR stage or a bus slave.

## Interface
- WORD_W, 32: output word width; ≥2.
- FIFO_DEPTH, 4: word FIFO depth; power of two, ≥2.
- RUN_LIMIT, 34: consecutive identical bits that trip health_fail; ≥2, used only with SNG_HEALTH_EN.

- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- bit_in  in  1  keystream bit from the generator.
- bit_en  in  1  bit_in is valid this cycle.
- flush  in  1  synchronous clear of the partial word and the FIFO.
- out_data  out  WORD_W  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data.
- level  out  $clog2(FIFO_DEPTH+1)  words currently in the FIFO.
- overflow  out  1  sticky: a completed word was dropped.
- health_fail  out  1  sticky: run-length test tripped.

## Operation
- Packing
  - Shift register `shreg` (WORD_W-1 bits) plus bit counter `bcnt` (0..WORD_W-1).
  - Each bit_en=1 cycle shifts bit_in in at the LSB. The first bit of a word therefore ends up in out_data[WORD_W-1].
  - When bcnt==WORD_W-1 and bit_en=1, the word {shreg, bit_in} is pushed to the FIFO and bcnt wraps to 0.
  - bit_en=0 holds all packing state.
- FIFO
  - A pop occurs when out_valid && out_ready.
  - Push while full with no pop in the same cycle: the word is discarded, FIFO contents are unchanged, overflow is set to 1.
  - Push while full with a pop in the same cycle: both are performed, level stays FIFO_DEPTH, overflow is not set.
  - Pop while empty is impossible because out_valid=0.
- flush=1
  - Clears bcnt, shreg and the FIFO (level=0, out_valid=0) and resets the run counter.
  - Overrides any push or pop in the same cycle; the bit presented that cycle is discarded.
  - Does not clear overflow or health_fail.
- rst=0
  - Clears everything, including the sticky flags.
  - A partial word in progress is lost; packing restarts at bit WORD_W-1 of the next word.
- Reset values: out_data=0, out_valid=0, level=0, overflow=0, health_fail=0.
- out_data is driven from the FIFO read slot and is undefined-free: it reads 0 after reset or flush until the first push.

## Timing
- Latency: the word appears on out_data with out_valid=1 in the cycle after the edge that samples its final bit.
- level updates on the same edge as the push or pop.
- Throughput: one bit per cycle in, one word per cycle out. The FIFO never limits a consumer holding out_ready=1.
- overflow and health_fail are asserted in the cycle after the triggering edge, then hold until rst=0.
- out_data and out_valid must stay stable while out_valid=1 && out_ready=0.

## Configuration
- Macro: SNG_HEALTH_EN.
- Defined:
  - Run counter `run` (saturating at RUN_LIMIT) and register `last_bit`.
  - On each bit_en cycle, run=1 if this is the first bit after reset/flush or bit_in≠last_bit, otherwise run+1.
  - When run reaches RUN_LIMIT, health_fail is set.
  - Packing continues regardless of health_fail.
- Undefined: no counter is instantiated, and health_fail is tied to 0.
- The port list is identical in both builds.

## Structure
- Shared package sng_pkg holds:
  - default localparams SNG_WORD_W=32, SNG_FIFO_DEPTH=4 and SNG_RUN_LIMIT=34;
  - typedef sng_word_t (logic [SNG_WORD_W-1:0]).
- Sub-module sng_sync_fifo:
  - parameterised width/depth, registered level, full/empty, synchronous active-low reset and flush;
  - implements the simultaneous push/pop-when-full rule.
- Packer, overflow logic and health monitor stay in sng_word_packer.

## Test plan
All scenarios use WORD_W=8, FIFO_DEPTH=2, RUN_LIMIT=34.
- Basic pack: bits 1,0,1,1,0,0,1,0 with bit_en=1 and out_ready=1 -> out_data=8'hB2 and out_valid=1 for exactly one cycle, starting the cycle after the 8th bit edge.
- Stall: bit_en=0 for 3 cycles between bits 4 and 5 of the same pattern -> still 8'hB2, with the valid cycle delayed by 3.
- Overflow and backpressure:
  - out_ready=0 with 24 bits in -> level=2, overflow=1 after the 24th bit, words 1 and 2 retained in order;
  - then out_ready=1 -> exactly two words drain.
- Full push+pop: FIFO full, out_ready=1 in the same cycle as a word completes -> level stays 2, overflow stays 0, words in order.
- Reset/flush mid-word:
  - 5 bits, then flush for 1 cycle, then 8 bits 0xA5 -> out_data=8'hA5;
  - overflow set before the flush stays 1; rst=0 clears it.
- Health (SNG_HEALTH_EN): 33 ones then a 0 -> health_fail=0; 34 ones -> health_fail=1 the cycle after the 34th bit edge, with packing unaffected. Without the macro, health_fail stays 0.
